// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT ping-pong coefficient RAM.
package ntt_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  localparam int DEF_DATA_WIDTH = 60;
  localparam int DEF_LOG_DEPTH  = 5;

endpackage

// File: rtl/ntt_sdp_bank.sv
// Simple dual-port synchronous RAM bank with registered read port.
// The read register resets to zero and holds between reads.
module ntt_sdp_bank #(
  parameter int W  = 60,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/ntt_pingpong_ram.sv
// Double-buffered NTT coefficient RAM with commit/release bank handshake.
// Optional per-word even parity: define NTT_RAM_PARITY_EN.
module ntt_pingpong_ram
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG_DEPTH  = DEF_LOG_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [LOG_DEPTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [LOG_DEPTH-1:0]  rd_addr,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            frames_pending,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  rd_parity_err
);

`ifdef NTT_RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = DATA_WIDTH + PW;

  bank_state_e st_q [2];
  bank_state_e st_d [2];
  logic        wb_q, wb_d;
  logic        rb_q, rb_d;
  logic [1:0]  fp_q, fp_d;
  logic        sel_q;

  logic wr_acc, commit, rd_acc, rel;

  logic [MW-1:0] wword;
  logic [MW-1:0] q0, q1, qsel;

  assign wr_acc = wr_en & wr_ready;
  assign commit = wr_acc & wr_last;
  assign rd_acc = rd_en & rd_ready;
  assign rel    = rd_done & rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0] <= FREE;
      st_q[1] <= FREE;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      fp_q    <= 2'd0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      fp_q    <= fp_d;
    end
  end

  // Accepted write and read always hit different banks.
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    wb_d    = wb_q;
    rb_d    = rb_q;
    fp_d    = fp_q;
    if (wr_acc) begin
      st_d[wb_q] = wr_last ? FULL : FILLING;
      if (wr_last) wb_d = ~wb_q;
    end
    if (rd_acc && st_q[rb_q] == FULL)
      st_d[rb_q] = DRAINING;
    if (rel) begin
      st_d[rb_q] = FREE;
      rb_d       = ~rb_q;
    end
    case ({commit, rel})
      2'b10:   fp_d = fp_q + 2'd1;
      2'b01:   fp_d = fp_q - 2'd1;
      default: fp_d = fp_q;
    endcase
  end

  always_comb begin
    wr_ready = (st_q[wb_q] == FREE) || (st_q[wb_q] == FILLING);
    rd_ready = (st_q[rb_q] == FULL) || (st_q[rb_q] == DRAINING);
    frames_pending = fp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid      <= 1'b0;
      sel_q         <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) sel_q <= rb_q;
      if (wr_en && !wr_ready) err_overflow <= 1'b1;
      if ((rd_en || rd_done) && !rd_ready) err_underflow <= 1'b1;
    end
  end

`ifdef NTT_RAM_PARITY_EN
  assign wword = {^wr_data, wr_data};
`else
  assign wword = wr_data;
`endif

  ntt_sdp_bank #(.W(MW), .AW(LOG_DEPTH)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~wb_q),
    .waddr (wr_addr),
    .wdata (wword),
    .re    (rd_acc & ~rb_q),
    .raddr (rd_addr),
    .q     (q0)
  );

  ntt_sdp_bank #(.W(MW), .AW(LOG_DEPTH)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & wb_q),
    .waddr (wr_addr),
    .wdata (wword),
    .re    (rd_acc & rb_q),
    .raddr (rd_addr),
    .q     (q1)
  );

  // Each bank's read register holds, so muxing by last read bank holds rd_data.
  assign qsel    = sel_q ? q1 : q0;
  assign rd_data = qsel[DATA_WIDTH-1:0];

`ifdef NTT_RAM_PARITY_EN
  assign rd_parity_err = rd_valid & (^qsel);
`else
  assign rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_pingpong_ram.sv
// Self-checking bench for ntt_pingpong_ram: frame-level model plus
// directed literal checks.
module tb_ntt_pingpong_ram;

  localparam int DW = 60;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_done = 1'b0;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    frames_pending;
  logic          err_overflow;
  logic          err_underflow;
  logic          rd_parity_err;

  int tests = 0;
  int fails = 0;

  ntt_pingpong_ram #(.DATA_WIDTH(DW), .LOG_DEPTH(AW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .wr_ready       (wr_ready),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_done        (rd_done),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .frames_pending (frames_pending),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow),
    .rd_parity_err  (rd_parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame-level model: ownership reduces to a count of committed frames
  // and two toggling bank pointers.
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_n = 0;
  bit            m_wp = 0;
  bit            m_rp = 0;
  bit            m_valid = 0;
  logic [DW-1:0] m_data = '0;
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            m_wacc, m_racc, m_rel, m_commit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_wp = 0; m_rp = 0;
      m_valid = 0; m_data = '0;
      m_ovf = 0; m_unf = 0;
    end else begin
      m_wacc = wr_en && (m_n < 2);
      m_racc = rd_en && (m_n > 0);
      m_rel  = rd_done && (m_n > 0);
      m_commit = m_wacc && wr_last;
      if (wr_en && !m_wacc) m_ovf = 1;
      if ((rd_en || rd_done) && m_n == 0) m_unf = 1;
      m_valid = m_racc;
      if (m_racc) m_data = m_mem[m_rp][rd_addr];
      if (m_wacc) m_mem[m_wp][wr_addr] = wr_data;
      if (m_commit) m_wp = ~m_wp;
      if (m_rel) m_rp = ~m_rp;
      m_n = m_n + int'(m_commit) - int'(m_rel);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_ready", 64'(wr_ready), 64'(m_n < 2));
      chk("rd_ready", 64'(rd_ready), 64'(m_n > 0));
      chk("frames_pending", 64'(frames_pending), 64'(m_n));
      chk("rd_valid", 64'(rd_valid), 64'(m_valid));
      chk("rd_data", 64'(rd_data), 64'(m_data));
      chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
      chk("err_underflow", 64'(err_underflow), 64'(m_unf));
`ifndef NTT_RAM_PARITY_EN
      chk("rd_parity_err", 64'(rd_parity_err), 64'd0);
`endif
    end
  end

  // Drive one cycle of inputs; returns just after the sampling edge.
  task automatic step(input bit we, input int wa, input int wd,
                      input bit wl, input bit re, input int ra,
                      input bit rdn);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = DW'(wd);
    wr_last = wl;
    rd_en   = re;
    rd_addr = AW'(ra);
    rd_done = rdn;
    @(posedge clk);
    #2;
    wr_en = 0; wr_last = 0; rd_en = 0; rd_done = 0;
  endtask

  initial begin
    #1;
    chk("rst frames_pending", 64'(frames_pending), 64'd0);
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst rd_data", 64'(rd_data), 64'd0);
    chk("rst wr_ready", 64'(wr_ready), 64'd1);
    chk("rst rd_ready", 64'(rd_ready), 64'd0);
    #11 rst = 0;
    @(posedge clk); #2;

    // 1: fill bank 0 and read one word back
    for (int a = 0; a < DEPTH; a++)
      step(1, a, 100 + a, a == DEPTH - 1, 0, 0, 0);
    chk("t1 frames_pending", 64'(frames_pending), 64'd1);
    chk("t1 rd_ready", 64'(rd_ready), 64'd1);
    chk("t1 wr_ready", 64'(wr_ready), 64'd1);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("t1 rd_valid", 64'(rd_valid), 64'd1);
    chk("t1 rd_data", 64'(rd_data), 64'd101);

    // 2/3: fill bank 1 while draining bank 0, then overflow
    for (int a = 0; a < DEPTH; a++)
      step(1, a, 200 + a, a == DEPTH - 1, 1, a, 0);
    chk("t3 frames_pending", 64'(frames_pending), 64'd2);
    chk("t3 wr_ready", 64'(wr_ready), 64'd0);
    step(0, 0, 0, 0, 1, 4, 0);
    chk("t2 bank0 still read", 64'(rd_data), 64'd104);
    step(1, 3, 999, 1, 0, 0, 0);
    chk("t3 err_overflow", 64'(err_overflow), 64'd1);
    chk("t3 frames_pending after drop", 64'(frames_pending), 64'd2);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 2, 0);
    chk("t2 bank1 addr2", 64'(rd_data), 64'd202);
    step(0, 0, 0, 0, 1, 3, 0);
    chk("t3 bank1 addr3", 64'(rd_data), 64'd203);

    // 4: underflow after releasing the last frame
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t4 rd_ready", 64'(rd_ready), 64'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t4 rd_valid", 64'(rd_valid), 64'd0);
    chk("t4 err_underflow", 64'(err_underflow), 64'd1);
    chk("t4 rd_data held", 64'(rd_data), 64'd203);

    // 5: commit bank 1 and release bank 0 in one cycle
    for (int a = 0; a < DEPTH; a++)
      step(1, a, 300 + a, a == DEPTH - 1, 0, 0, 0);
    for (int a = 0; a < DEPTH - 1; a++)
      step(1, a, 400 + a, 0, 0, 0, 0);
    step(1, DEPTH - 1, 431, 1, 1, 9, 1);
    chk("t5 same-cycle read", 64'(rd_data), 64'd309);
    chk("t5 frames_pending", 64'(frames_pending), 64'd1);
    chk("t5 rd_ready", 64'(rd_ready), 64'd1);
    chk("t5 wr_ready", 64'(wr_ready), 64'd1);
    step(0, 0, 0, 0, 1, 7, 0);
    chk("t5 bank1 addr7", 64'(rd_data), 64'd407);

    // 6: reset in the middle of a fill
    for (int a = 0; a < 10; a++)
      step(1, a, 500 + a, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk("t6 frames_pending", 64'(frames_pending), 64'd0);
    chk("t6 rd_valid", 64'(rd_valid), 64'd0);
    chk("t6 rd_data", 64'(rd_data), 64'd0);
    chk("t6 err_overflow", 64'(err_overflow), 64'd0);
    chk("t6 err_underflow", 64'(err_underflow), 64'd0);
    chk("t6 wr_ready", 64'(wr_ready), 64'd1);
    chk("t6 rd_ready", 64'(rd_ready), 64'd0);
    chk("t6 rd_parity_err", 64'(rd_parity_err), 64'd0);
    @(posedge clk); #2;
    rst = 0;
    @(posedge clk); #2;

`ifdef NTT_RAM_PARITY_EN
    for (int a = 0; a < DEPTH; a++)
      step(1, a, 600 + a, a == DEPTH - 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 0);
    chk("t6 parity clean", 64'(rd_parity_err), 64'd0);
    u_dut.u_bank0.mem[5][DW] = ~u_dut.u_bank0.mem[5][DW];
    step(0, 0, 0, 0, 1, 5, 0);
    chk("t6 parity rd_valid", 64'(rd_valid), 64'd1);
    chk("t6 parity err", 64'(rd_parity_err), 64'd1);
    chk("t6 parity data", 64'(rd_data), 64'd605);
`else
    for (int a = 0; a < DEPTH; a++)
      step(1, a, 600 + a, a == DEPTH - 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0);
    chk("t6 refill data", 64'(rd_data), 64'd605);
`endif
    step(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntt_pingpong_ram.md
Name: ntt_pingpong_ram

Overview:
Parametrised double-buffered coefficient RAM between the NTT load path and the butterfly cores.
- Generalises the manual write_select/read_select ping-pong RAM.
- Bank ownership is tracked by an internal handshake, so bank swaps follow frame commit/release events and need no external select lines.
- The producer fills one bank while the consumer drains the other.

Parameters:
DATA_WIDTH, 60, coefficient word width in bits
LOG_DEPTH, 5, log2 of words per bank (bank depth = 2**LOG_DEPTH)

Ports:
clk  input  1  single clock; all logic is rising-edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe
wr_addr  input  LOG_DEPTH  write word address within the current write bank
wr_data  input  DATA_WIDTH  write data
wr_last  input  1  with an accepted write: commit the write bank as a full frame
wr_ready  output  1  the current write bank accepts writes
rd_en  input  1  read strobe
rd_addr  input  LOG_DEPTH  read word address within the current read bank
rd_done  input  1  release the current read bank
rd_ready  output  1  a committed frame is available for reading
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  rd_data is valid this cycle
frames_pending  output  2  number of committed, unreleased banks (0..2)
err_overflow  output  1  sticky flag: write attempted while wr_ready=0
err_underflow  output  1  sticky flag: read or release attempted while rd_ready=0
rd_parity_err  output  1  parity mismatch on the read word (see Optional Feature)

Behaviour:
- Two banks, each 2**LOG_DEPTH x DATA_WIDTH. Per-bank state is FREE, FILLING, FULL or DRAINING. The 1-bit pointers wb and rb select the write and read banks.
- Reset (async, immediate):
  - both banks FREE; wb=rb=0
  - rd_data=0, rd_valid=0, frames_pending=0
  - err_overflow=0, err_underflow=0, rd_parity_err=0
  - RAM contents are not cleared.
- Reset asserted mid-frame discards all partial and committed frames.
- wr_ready = (state[wb] is FREE or FILLING). It is combinational from state only.
- Accepted write = wr_en & wr_ready:
  - mem[wb][wr_addr] <= wr_data
  - FREE -> FILLING
  - if wr_last also set: -> FULL, wb toggles, frames_pending +1
- wr_last without wr_en has no effect.
- wr_en & !wr_ready: write dropped, err_overflow <= 1 (sticky until reset).
- Address order is unconstrained. Rewriting an address overwrites it. Unwritten words read back stale contents.
- rd_ready = (state[rb] is FULL or DRAINING).
- Accepted read = rd_en & rd_ready:
  - the first read moves FULL -> DRAINING
  - rd_data <= mem[rb][rd_addr], with rd_valid=1 on the next cycle (latency 1)
  - rd_valid is high for exactly one cycle per accepted read
  - rd_data holds its last value when rd_valid=0
- rd_done & rd_ready: bank -> FREE, rb toggles, frames_pending -1. A read issued in the same cycle is still served from the bank being released.
- rd_en or rd_done while !rd_ready: ignored, err_underflow <= 1 (sticky).
- Write commit and read release in the same cycle always target different banks. Both take effect, and frames_pending is unchanged.
- Both banks FULL: wr_ready=0 and frames_pending=2.
- Both banks FREE: rd_ready=0 and frames_pending=0.
- The write and read paths never access the same bank in the same cycle, so no read-during-write hazard exists.

Optional Feature:
NTT_RAM_PARITY_EN
- Defined:
  - each word stores one extra even-parity bit computed from wr_data
  - on read, parity is recomputed; rd_parity_err=1 in the same cycle as rd_valid when it mismatches, else 0
- Undefined: no parity storage, and rd_parity_err is tied to 0.

Decomposition:
- Shared package ntt_pkg holds:
  - bank-state encoding: FREE=2'd0, FILLING=2'd1, FULL=2'd2, DRAINING=2'd3
  - default DATA_WIDTH and LOG_DEPTH constants
- One natural sub-module, ntt_sdp_bank: a simple dual-port synchronous RAM with registered read, instantiated twice.
- Bank control (states, pointers, counters, errors) lives in the top level.

Test Plan:
1. Reset, then write addr 0..31 with data 100+addr and wr_last on addr 31 -> wr_ready stays 1, frames_pending=1, rd_ready=1. Reading addr 1 gives rd_data=101 with rd_valid one cycle later.
2. While bank 0 drains, write bank 1 with 200+addr and commit. Reads of bank 0 still return 100+addr. rd_done -> rb=1, and reading addr 2 returns 202.
3. Commit two frames without reading -> frames_pending=2, wr_ready=0. A further wr_en sets err_overflow=1 and leaves memory unchanged.
4. rd_en with no committed frame -> rd_valid stays 0, err_underflow=1.
5. Same cycle: wr_last commits bank 1 and rd_done releases bank 0 -> frames_pending stays 1, rd_ready=1, wr_ready=1.
6. Assert rst mid-fill after 10 writes -> every output returns to its reset value at once, wr_ready=1, rd_ready=0. With NTT_RAM_PARITY_EN defined, a forced parity-bit flip on addr 5 gives rd_parity_err=1 together with rd_valid.
